// File: rtl/fpu_buffer_dma.sv
// Buffer DMA responder for the FPU controller: empties a write buffer to memory
// and fills a read buffer from memory, stalling the controller while busy.
module fpu_buffer_dma #(
  parameter int unsigned COL_WIDTH        = 10,
  parameter int unsigned MEM_BUFFER_WIDTH = 512,
  parameter int unsigned MAX_OUTSTANDING  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  input  logic                                req_read,
  input  logic                                req_write,
  input  logic                                req_buf_sel,
  input  logic [31:0]                         req_read_address,
  input  logic [31:0]                         req_write_address,
  input  logic [$clog2(MEM_BUFFER_WIDTH):0]   req_width,
  input  logic [$clog2(COL_WIDTH):0]          req_height,
  input  logic [31:0]                         in_stride,
  input  logic [31:0]                         out_stride,
  output logic                                busy,
  output logic                                done,
  output logic                                rbuf_wr_en,
  output logic                                rbuf_sel,
  output logic [$clog2(COL_WIDTH)-1:0]        rbuf_row,
  output logic [$clog2(MEM_BUFFER_WIDTH)-1:0] rbuf_col,
  output logic [7:0]                          rbuf_wdata,
  output logic                                wbuf_rd_en,
  output logic                                wbuf_sel,
  output logic [$clog2(COL_WIDTH)-1:0]        wbuf_row,
  output logic [$clog2(MEM_BUFFER_WIDTH)-1:0] wbuf_col,
  input  logic [7:0]                          wbuf_rdata,
  output logic [31:0]                         mem_addr,
  output logic                                mem_rd,
  output logic                                mem_wr,
  output logic [7:0]                          mem_wdata,
  input  logic                                mem_ready,
  input  logic [7:0]                          mem_rdata,
  input  logic                                mem_rvalid
);

  localparam int unsigned RW = $clog2(COL_WIDTH);
  localparam int unsigned CW = $clog2(MEM_BUFFER_WIDTH);
  localparam int unsigned WW = CW + 1;
  localparam int unsigned HW = RW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EMPTY = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rd_flag_q, sel_q;
  logic [WW-1:0] width_q;
  logic [HW-1:0] height_q;
  logic [31:0]   in_stride_q, out_stride_q;

  // Empty side: wbuf read issue counters plus a one-entry command holding register
  logic [RW-1:0] wr_row_q;
  logic [CW-1:0] wr_col_q;
  logic [31:0]   wr_base_q;
  logic          wr_all_q;
  logic          cmd_valid_q, cmd_fresh_q;
  logic [31:0]   cmd_addr_q;
  logic [7:0]    cmd_data_q;

  // Fill side: independent issue and response counters
  logic [RW-1:0] fi_row_q, fr_row_q;
  logic [CW-1:0] fi_col_q, fr_col_q;
  logic [31:0]   fi_base_q;
  logic          fi_all_q;
  logic [OW-1:0] outst_q;

  logic          accept_c, in_empty_c, in_fill_c;
  logic          wr_issue_c, wr_drain_c, wr_last_col_c, wr_last_row_c, empty_end_c;
  logic          rd_issue_c, rsp_c, fi_last_col_c, fi_last_row_c, fill_end_c;
  logic [WW-1:0] w_clamp_c;
  logic [HW-1:0] h_clamp_c;

  assign accept_c   = (state_q == S_IDLE) && req_valid && (req_read || req_write);
  assign in_empty_c = (state_q == S_EMPTY);
  assign in_fill_c  = (state_q == S_FILL);
  assign w_clamp_c  = (req_width > WW'(MEM_BUFFER_WIDTH)) ? WW'(MEM_BUFFER_WIDTH) : req_width;
  assign h_clamp_c  = (req_height > HW'(COL_WIDTH)) ? HW'(COL_WIDTH) : req_height;

  // A new wbuf read may only start when the holding register is free or draining
  assign wr_issue_c    = in_empty_c && !wr_all_q && (!cmd_valid_q || mem_ready);
  assign wr_drain_c    = in_empty_c && cmd_valid_q && mem_ready;
  assign wr_last_col_c = (WW'(wr_col_q) + WW'(1)) == width_q;
  assign wr_last_row_c = (HW'(wr_row_q) + HW'(1)) == height_q;
  assign empty_end_c   = in_empty_c && wr_all_q && (!cmd_valid_q || mem_ready);

  assign mem_rd        = in_fill_c && !fi_all_q && (outst_q < OW'(MAX_OUTSTANDING));
  assign rd_issue_c    = mem_rd && mem_ready;
  assign rsp_c         = in_fill_c && mem_rvalid;
  assign fi_last_col_c = fi_col_q == CW'(MEM_BUFFER_WIDTH - 1);
  assign fi_last_row_c = fi_row_q == RW'(COL_WIDTH - 1);
  assign fill_end_c    = rsp_c && (fr_row_q == RW'(COL_WIDTH - 1)) &&
                         (fr_col_q == CW'(MEM_BUFFER_WIDTH - 1));

  assign mem_wr     = in_empty_c && cmd_valid_q;
  assign mem_wdata  = mem_wr ? (cmd_fresh_q ? wbuf_rdata : cmd_data_q) : 8'd0;
  assign mem_addr   = mem_wr ? cmd_addr_q : (mem_rd ? fi_base_q + 32'(fi_col_q) : 32'd0);
  assign wbuf_rd_en = wr_issue_c;
  assign wbuf_row   = wr_row_q;
  assign wbuf_col   = wr_col_q;
  assign wbuf_sel   = sel_q;
  assign rbuf_wr_en = rsp_c;
  assign rbuf_wdata = rsp_c ? mem_rdata : 8'd0;
  assign rbuf_row   = fr_row_q;
  assign rbuf_col   = fr_col_q;
  assign rbuf_sel   = sel_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = req_write ? S_EMPTY : S_FILL;
      S_EMPTY: begin
        busy = 1'b1;
        if (empty_end_c) state_d = rd_flag_q ? S_FILL : S_DONE;
      end
      S_FILL: begin
        busy = 1'b1;
        if (fill_end_c) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_flag_q <= 1'b0; sel_q <= 1'b0; width_q <= '0; height_q <= '0;
      in_stride_q <= '0; out_stride_q <= '0;
      wr_row_q <= '0; wr_col_q <= '0; wr_base_q <= '0; wr_all_q <= 1'b0;
      cmd_valid_q <= 1'b0; cmd_fresh_q <= 1'b0; cmd_addr_q <= '0; cmd_data_q <= '0;
      fi_row_q <= '0; fi_col_q <= '0; fi_base_q <= '0; fi_all_q <= 1'b0;
      fr_row_q <= '0; fr_col_q <= '0; outst_q <= '0;
    end else begin
      if (accept_c) begin
        rd_flag_q    <= req_read;
        sel_q        <= req_buf_sel;
        width_q      <= w_clamp_c;
        height_q     <= h_clamp_c;
        in_stride_q  <= in_stride;
        out_stride_q <= out_stride;
        wr_row_q     <= '0;
        wr_col_q     <= '0;
        wr_base_q    <= req_write_address;
        wr_all_q     <= (w_clamp_c == '0) || (h_clamp_c == '0);
        cmd_valid_q  <= 1'b0;
        cmd_fresh_q  <= 1'b0;
        fi_row_q     <= '0;
        fi_col_q     <= '0;
        fi_base_q    <= req_read_address;
        fi_all_q     <= 1'b0;
        fr_row_q     <= '0;
        fr_col_q     <= '0;
        outst_q      <= '0;
      end

      if (wr_issue_c) begin
        cmd_valid_q <= 1'b1;
        cmd_fresh_q <= 1'b1;
        cmd_addr_q  <= wr_base_q + 32'(wr_col_q);
        if (wr_last_col_c) begin
          wr_col_q <= '0;
          if (wr_last_row_c) wr_all_q <= 1'b1;
          else begin
            wr_row_q  <= wr_row_q + RW'(1);
            wr_base_q <= wr_base_q + out_stride_q;
          end
        end else begin
          wr_col_q <= wr_col_q + CW'(1);
        end
      end else if (wr_drain_c) begin
        cmd_valid_q <= 1'b0;
        cmd_fresh_q <= 1'b0;
      end else if (in_empty_c && cmd_valid_q && cmd_fresh_q) begin
        // Stalled command: keep the byte, the buffer read port may move on
        cmd_data_q  <= wbuf_rdata;
        cmd_fresh_q <= 1'b0;
      end

      if (rd_issue_c) begin
        if (fi_last_col_c) begin
          fi_col_q <= '0;
          if (fi_last_row_c) fi_all_q <= 1'b1;
          else begin
            fi_row_q  <= fi_row_q + RW'(1);
            fi_base_q <= fi_base_q + in_stride_q;
          end
        end else begin
          fi_col_q <= fi_col_q + CW'(1);
        end
      end

      if (rsp_c) begin
        if (fi_last_col_c && 1'b0) fr_col_q <= '0;
        if (fr_col_q == CW'(MEM_BUFFER_WIDTH - 1)) begin
          fr_col_q <= '0;
          fr_row_q <= (fr_row_q == RW'(COL_WIDTH - 1)) ? '0 : fr_row_q + RW'(1);
        end else begin
          fr_col_q <= fr_col_q + CW'(1);
        end
      end

      if (rd_issue_c && !rsp_c)      outst_q <= outst_q + OW'(1);
      else if (!rd_issue_c && rsp_c) outst_q <= outst_q - OW'(1);
    end
  end

endmodule

// File: tb/tb_fpu_buffer_dma.sv
// Scoreboard bench for fpu_buffer_dma: randomized requests against a reference
// model of the byte moves, with memory and write-buffer models driving the DUT.
module tb_fpu_buffer_dma;

  localparam int unsigned COLW = 10;
  localparam int unsigned MBW  = 512;
  localparam int unsigned MAXO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_read, req_write, req_buf_sel;
  logic [31:0] req_read_address, req_write_address, in_stride, out_stride;
  logic [9:0]  req_width;
  logic [4:0]  req_height;
  logic        busy, done, rbuf_wr_en, rbuf_sel, wbuf_rd_en, wbuf_sel;
  logic [3:0]  rbuf_row, wbuf_row;
  logic [8:0]  rbuf_col, wbuf_col;
  logic [7:0]  rbuf_wdata, wbuf_rdata, mem_wdata, mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr, mem_ready, mem_rvalid;

  fpu_buffer_dma #(.COL_WIDTH(COLW), .MEM_BUFFER_WIDTH(MBW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_buf_sel(req_buf_sel), .req_read_address(req_read_address),
    .req_write_address(req_write_address), .req_width(req_width), .req_height(req_height),
    .in_stride(in_stride), .out_stride(out_stride), .busy(busy), .done(done),
    .rbuf_wr_en(rbuf_wr_en), .rbuf_sel(rbuf_sel), .rbuf_row(rbuf_row), .rbuf_col(rbuf_col),
    .rbuf_wdata(rbuf_wdata), .wbuf_rd_en(wbuf_rd_en), .wbuf_sel(wbuf_sel),
    .wbuf_row(wbuf_row), .wbuf_col(wbuf_col), .wbuf_rdata(wbuf_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid));

  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [3:0] row; logic [8:0] col; logic [7:0] data; } rb_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  rb_t         exp_rb[$];
  pend_t       pend_q[$];

  int checks = 0, failures = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, last_rsp_cyc = 0, rsp_cnt = 0, tb_outst = 0;
  bit exp_sel = 1'b0, rnd_ready = 1'b0, wbuf_pend = 1'b0;
  logic       wp_sel;
  logic [3:0] wp_row;
  logic [8:0] wp_col;
  int cur_acc, cur_d0;
  int unsigned cur_wc, cur_hc;
  bit cur_rd, cur_wr;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3c;
  endfunction

  function automatic logic [7:0] wbuf_byte(input logic s, input logic [3:0] r, input logic [8:0] c);
    return 8'(32'(c) * 7 + 32'(r) * 31 + 32'(s) * 97 + 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h (cycle %0d)", name, act, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ctl"}, 64'({busy, done, mem_rd, mem_wr, rbuf_wr_en, wbuf_rd_en, rbuf_sel, wbuf_sel}), 64'd0);
    chk({name, "_data"}, 64'({mem_addr, mem_wdata, rbuf_wdata}), 64'd0);
    chk({name, "_idx"}, 64'({rbuf_row, rbuf_col, wbuf_row, wbuf_col}), 64'd0);
  endtask

  // Memory and write-buffer models, driven mid-cycle
  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'd0; wbuf_rdata = 8'd0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_ready = rnd_ready ? 1'($urandom & 1) : 1'b1;
      if (wbuf_pend) wbuf_rdata = wbuf_byte(wp_sel, wp_row, wp_col);
      else           wbuf_rdata = 8'($urandom);
      wbuf_pend = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_byte(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transfer
  initial begin
    bit hchk;
    logic [31:0] haddr;
    logic [7:0]  hdata;
    wr_t w;
    rb_t b;
    pend_t p;
    int o;
    hchk = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hchk = 1'b0;
        continue;
      end
      if (hchk) chk("wr_stable", 64'({mem_wr, mem_addr, mem_wdata}), 64'({1'b1, haddr, hdata}));
      hchk  = mem_wr && !mem_ready;
      haddr = mem_addr;
      hdata = mem_wdata;
      chk("rd_wr_overlap", 64'(mem_rd & mem_wr), 64'd0);
      if (mem_wr && mem_ready) begin
        if (exp_wr.size() == 0) fail_now("wr_extra", 64'(mem_addr));
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr_data", 64'({mem_addr, mem_wdata}), 64'({w.addr, w.data}));
        end
        last_wr_cyc = cyc;
      end
      o = tb_outst;
      if (mem_rd && mem_ready) begin
        chk("wr_before_rd", 64'(exp_wr.size()), 64'd0);
        if (exp_rd.size() == 0) fail_now("rd_extra", 64'(mem_addr));
        else chk("rd_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
        p.addr = mem_addr;
        p.due  = cyc + 3;
        pend_q.push_back(p);
        o++;
        chk("outstanding_max", 64'(o > int'(MAXO)), 64'd0);
      end
      if (rbuf_wr_en) begin
        if (exp_rb.size() == 0) fail_now("rbuf_extra", 64'({rbuf_row, rbuf_col}));
        else begin
          b = exp_rb.pop_front();
          chk("rbuf_write", 64'({rbuf_row, rbuf_col, rbuf_wdata}), 64'({b.row, b.col, b.data}));
        end
        chk("rbuf_sel", 64'(rbuf_sel), 64'(exp_sel));
        o--;
        rsp_cnt++;
        last_rsp_cyc = cyc;
      end
      tb_outst = o;
      if (wbuf_rd_en) begin
        wbuf_pend = 1'b1;
        wp_sel = wbuf_sel; wp_row = wbuf_row; wp_col = wbuf_col;
        chk("wbuf_sel", 64'(wbuf_sel), 64'(exp_sel));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference model: every byte move the request should cause, in order
  task automatic issue_req(input bit rd, input bit wr, input bit sel, input logic [31:0] ra,
                           input logic [31:0] wa, input int unsigned w, input int unsigned h,
                           input logic [31:0] is, input logic [31:0] os, input bit rr);
    logic [31:0] a;
    wr_t we;
    rb_t be;
    cur_wc = (w > MBW) ? MBW : w;
    cur_hc = (h > COLW) ? COLW : h;
    cur_rd = rd;
    cur_wr = wr;
    if (wr)
      for (int r = 0; r < int'(cur_hc); r++)
        for (int c = 0; c < int'(cur_wc); c++) begin
          we.addr = wa + 32'(r) * os + 32'(c);
          we.data = wbuf_byte(sel, 4'(r), 9'(c));
          exp_wr.push_back(we);
        end
    if (rd)
      for (int r = 0; r < int'(COLW); r++)
        for (int c = 0; c < int'(MBW); c++) begin
          a = ra + 32'(r) * is + 32'(c);
          exp_rd.push_back(a);
          be.row = 4'(r); be.col = 9'(c); be.data = mem_byte(a);
          exp_rb.push_back(be);
        end
    rnd_ready = rr;
    exp_sel   = sel;
    cur_d0    = done_cnt;
    tick();
    req_valid = 1'b1; req_read = rd; req_write = wr; req_buf_sel = sel;
    req_read_address = ra; req_write_address = wa; req_width = 10'(w); req_height = 5'(h);
    in_stride = is; out_stride = os;
    cur_acc = cyc;
    tick();
    req_valid = 1'b0;
    req_read = 1'($urandom); req_write = 1'($urandom); req_buf_sel = ~sel;
    req_read_address = $urandom; req_write_address = $urandom;
    req_width = 10'($urandom); req_height = 5'($urandom);
    in_stride = $urandom; out_stride = $urandom;
    chk("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic run_req(input bit rd, input bit wr, input bit sel, input logic [31:0] ra,
                         input logic [31:0] wa, input int unsigned w, input int unsigned h,
                         input logic [31:0] is, input logic [31:0] os, input bit rr, input bit poke);
    int n;
    issue_req(rd, wr, sel, ra, wa, w, h, is, os, rr);
    if (poke) begin
      repeat (5) begin
        tick();
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b1;
      end
      tick();
      req_valid = 1'b0;
    end
    n = 0;
    while (done_cnt == cur_d0 && n < 25000) begin
      tick();
      n++;
    end
    if (done_cnt == cur_d0) begin
      fail_now("done_timeout", 64'(n));
      rst = 1'b1;
      tick();
      exp_wr.delete(); exp_rd.delete(); exp_rb.delete();
      tb_outst = 0;
      rst = 1'b0;
    end else begin
      if (rd)
        chk("done_after_last_rsp", 64'(done_cyc), 64'(last_rsp_cyc + 1));
      else if (cur_wc == 0 || cur_hc == 0)
        chk("empty_one_cycle", 64'(done_cyc), 64'(cur_acc + 2));
      else
        chk("done_after_last_wr", 64'(done_cyc), 64'(last_wr_cyc + 1));
      tick();
      chk("busy_fall", 64'(busy), 64'd0);
      repeat (3) tick();
      chk("done_once", 64'(done_cnt - cur_d0), 64'd1);
      chk("wr_all_seen", 64'(exp_wr.size()), 64'd0);
      chk("rd_all_seen", 64'(exp_rd.size()), 64'd0);
      chk("rbuf_all_seen", 64'(exp_rb.size()), 64'd0);
    end
    rnd_ready = 1'b0;
  endtask

  initial begin
    int n, base;
    rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_buf_sel = 1'b0;
    req_read_address = '0; req_write_address = '0; req_width = '0; req_height = '0;
    in_stride = '0; out_stride = '0;
    repeat (3) tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    run_req(0, 1, 0, 32'h0, 32'h100, 5, 3, 32'd0, 32'd19, 0, 0);
    run_req(1, 0, 0, 32'h2000, 32'h0, 0, 0, 32'd681, 32'd0, 0, 1);
    run_req(1, 1, 1, 32'h4000, 32'h8000, 7, 4, 32'd681, 32'd25, 0, 1);
    run_req(0, 1, 0, 32'h0, 32'h100, 5, 3, 32'd0, 32'd19, 1, 0);
    run_req(0, 1, 1, 32'h0, 32'h3000, 600, 2, 32'd0, 32'd1540, 0, 1);
    run_req(0, 1, 0, 32'h0, 32'h5000, 3, 12, 32'd0, 32'd13, 0, 0);
    run_req(0, 1, 0, 32'h0, 32'h6000, 0, 5, 32'd0, 32'd19, 0, 0);
    run_req(0, 1, 1, 32'h0, 32'h6000, 5, 0, 32'd0, 32'd19, 0, 0);

    // Abort a fill part way through, then check a clean restart
    base = rsp_cnt;
    issue_req(1, 0, 1, 32'h0001_0000, 32'h0, 0, 0, 32'd777, 32'd0, 0);
    n = 0;
    while (rsp_cnt < base + 100 && n < 2000) begin
      tick();
      n++;
    end
    if (rsp_cnt < base + 100) fail_now("abort_wait_timeout", 64'(rsp_cnt - base));
    cur_d0 = done_cnt;
    rst = 1'b1;
    tick();
    chk_idle("reset_mid_fill");
    exp_wr.delete(); exp_rd.delete(); exp_rb.delete();
    tb_outst = 0;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("no_done_after_abort", 64'(done_cnt), 64'(cur_d0));
    run_req(1, 0, 0, 32'h2000, 32'h0, 0, 0, 32'd681, 32'd0, 0, 0);

    for (int k = 0; k < 4; k++)
      run_req(0, 1, 1'(k), 32'h0, $urandom, $urandom_range(70, 0), $urandom_range(12, 0),
              32'd0, 32'($urandom_range(300, 1)), 1, 0);
    run_req(1, 1, 0, 32'hFFFF_F800, 32'hFFFF_FFF0, 40, 3, 32'd681, 32'd124, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_buffer_dma.md
Name: fpu_buffer_dma

Overview:
- Responder for the FPU controller's buffer request interface: the controller issues read (fill) and write (empty) requests, and this block services them.
- Empty: copies a width×height byte region from the selected write buffer to main memory at the result-row stride.
- Fill: loads COL_WIDTH rows × MEM_BUFFER_WIDTH bytes from main memory at the input-row stride into the selected read buffer.
- Sits between the FPU controller/buffers and the memory arbiter. Drives the controller's stall (busy) while a transfer is in flight.

Parameters:
- COL_WIDTH, 10, number of buffer rows.
- MEM_BUFFER_WIDTH, 512, bytes per buffer row.
- MAX_OUTSTANDING, 4, maximum memory reads issued without a returned response (must be ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request strobe, sampled only in IDLE.
- req_read  in  1  request includes a fill.
- req_write  in  1  request includes an empty.
- req_buf_sel  in  1  target buffer index for both read and write buffers.
- req_read_address  in  32  byte address of fill row 0, column 0.
- req_write_address  in  32  byte address of empty row 0, column 0.
- req_width  in  $clog2(MEM_BUFFER_WIDTH)+1  bytes per row to empty.
- req_height  in  $clog2(COL_WIDTH)+1  rows to empty.
- in_stride  in  32  input image row stride in bytes, (width+2)*3.
- out_stride  in  32  output image row stride in bytes, width*3+4.
- busy  out  1  request in progress (controller stall).
- done  out  1  one-cycle pulse when the request completes.
- rbuf_wr_en  out  1  read-buffer byte write strobe.
- rbuf_sel  out  1  read-buffer select.
- rbuf_row  out  $clog2(COL_WIDTH)  read-buffer row index.
- rbuf_col  out  $clog2(MEM_BUFFER_WIDTH)  read-buffer column index.
- rbuf_wdata  out  8  byte written to the read buffer.
- wbuf_rd_en  out  1  write-buffer read strobe; data is returned 1 cycle later.
- wbuf_sel  out  1  write-buffer select.
- wbuf_row  out  $clog2(COL_WIDTH)  write-buffer row index.
- wbuf_col  out  $clog2(MEM_BUFFER_WIDTH)  write-buffer column index.
- wbuf_rdata  in  8  byte returned from the write buffer.
- mem_addr  out  32  memory byte address.
- mem_rd  out  1  memory read command.
- mem_wr  out  1  memory write command.
- mem_wdata  out  8  memory write data.
- mem_ready  in  1  memory accepts the current command this cycle.
- mem_rdata  in  8  memory read data.
- mem_rvalid  in  1  read data valid; responses return in order.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, outstanding count 0. Reset asserted mid-transfer aborts the transfer: no done pulse, and any late mem_rvalid is ignored until the next accept.
- States and transitions:
  - IDLE → (req_valid & (req_read | req_write)) → EMPTY if req_write, else FILL.
  - EMPTY → FILL if the captured read flag is set, else DONE.
  - FILL → DONE once all COL_WIDTH*MEM_BUFFER_WIDTH responses are written.
  - DONE → IDLE after 1 cycle.
  - req_valid with neither flag set: ignored.
- On accept, capture all req_* fields and strides; later input changes have no effect. busy rises the cycle after accept and falls in the DONE→IDLE cycle. done=1 in the DONE cycle only.
- Clamping: width is clamped to MEM_BUFFER_WIDTH and height to COL_WIDTH. If the clamped width or height is 0, EMPTY lasts exactly 1 cycle and issues no memory writes.
- EMPTY, row-major order:
  - Assert wbuf_rd_en at (row, col). Next cycle, present mem_wr=1, mem_addr = write_address + row*out_stride + col, mem_wdata = wbuf_rdata captured in a holding register.
  - Hold the command stable until mem_ready. Further wbuf reads are issued only when the holding register is empty or being drained this cycle, giving 1 byte/cycle sustained when mem_ready=1.
- FILL:
  - Issue mem_rd at addr = read_address + row*in_stride + col, row-major, while outstanding < MAX_OUTSTANDING. Issue counters advance on mem_rd & mem_ready.
  - Each mem_rvalid produces rbuf_wr_en=1 in the same cycle with rbuf_wdata = mem_rdata. Row/col for responses come from separate response counters.
  - Outstanding count: +1 on an accepted read, −1 on mem_rvalid; both in one cycle leaves it unchanged.
  - Leave FILL only when all responses have been received. mem_rd and mem_wr are never asserted together.
- All address arithmetic is 32-bit modulo 2^32.
- wbuf_sel = rbuf_sel = captured req_buf_sel for the whole request.

Test Plan:
- Write-only: width=5, height=3, write_address=0x100, out_stride=19, mem_ready=1 → exactly 15 mem_wr at 0x100–0x104, 0x113–0x117, 0x126–0x12A carrying the buffer bytes; done 1 cycle after the last write; busy low afterwards.
- Read-only: read_address=0x2000, in_stride=681, memory returning with 3-cycle latency → 5120 rbuf writes with row r, col c = mem[0x2000+681r+c]; outstanding never exceeds 4.
- Read+write: req_read=req_write=1, req_buf_sel=1 → all EMPTY writes complete before the first mem_rd; wbuf_sel=rbuf_sel=1 throughout; exactly one done pulse.
- Backpressure: random mem_ready (50%) during EMPTY → write count, addresses and data are identical to the mem_ready=1 run; commands stay stable while not accepted.
- Boundaries:
  - width=600 clamps to 512.
  - height=12 clamps to 10.
  - width=0 → no mem_wr.
  - req_valid asserted while busy → ignored.
- Reset mid-FILL after 100 responses → outputs 0 next cycle, no done; a new request then completes normally.
